// File: rtl/moving_average_pkg.sv
// Shared constants and helpers for the multi-channel moving-average filter.
// sat() works on a wide signed value and clamps it to a DATA_W-bit signed range.
package moving_average_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_DEPTH   = 74;
    localparam int DEF_SCALE_W = 24;
    localparam int DEF_SCALE   = 113359;
    localparam int DEF_SHIFT   = 23;
    localparam int SAT_W       = 128;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] x, input int w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = $signed((SAT_W'(1) << (w - 1)) - SAT_W'(1));
        lo = ~hi;
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/axis_moving_average_mc_delay_line.sv
// Circular sample buffer addressed as {slot, ch} with asynchronous read.
// Owns the slot pointer and per-channel fill counters; reports 0 until a channel's window is full.
module ma_delay_line
    import moving_average_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_CH = 1,
    parameter int CH_W   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic                     i_last,
    input  logic [CH_W-1:0]          i_ch,
    input  logic signed [DATA_W-1:0] i_data,
    output logic signed [DATA_W-1:0] o_old
);

    localparam int WORDS  = DEPTH * NUM_CH;
    localparam int ADDR_W = (clog2(WORDS) > 0) ? clog2(WORDS) : 1;
    localparam int SLOT_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
    localparam int FILL_W = clog2(DEPTH + 1);

    logic signed [DATA_W-1:0] r_mem [WORDS];
    logic [SLOT_W-1:0]        r_slot;
    logic [FILL_W-1:0]        r_fill [NUM_CH];
    logic [ADDR_W-1:0]        w_addr;
    logic                     w_full;

    assign w_addr = ADDR_W'(r_slot) * ADDR_W'(NUM_CH) + ADDR_W'(i_ch);
    assign w_full = (r_fill[i_ch] == FILL_W'(DEPTH));
    // Read-before-write: the word leaving the window is seen in the same cycle it is overwritten.
    assign o_old  = w_full ? r_mem[w_addr] : '0;

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[w_addr] <= i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= '0;
        end else if (i_we && i_last) begin
            r_slot <= (r_slot == SLOT_W'(DEPTH - 1)) ? '0 : r_slot + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++)
                r_fill[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (i_we && (i_ch == CH_W'(i)) && (r_fill[i] != FILL_W'(DEPTH)))
                    r_fill[i] <= r_fill[i] + 1'b1;
        end
    end

endmodule

// File: rtl/axis_moving_average_mc.sv
// AXI4-Stream multi-channel moving average: accumulate, multiply by 1/DEPTH, round and saturate.
// Three stages share one enable so backpressure freezes the whole pipeline.
module axis_moving_average_mc
    import moving_average_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int NUM_CH  = 1,
    parameter int SCALE_W = DEF_SCALE_W,
    parameter int SCALE   = DEF_SCALE,
    parameter int SHIFT   = DEF_SHIFT,
    localparam int CH_W   = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic signed [DATA_W-1:0] s_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic signed [DATA_W-1:0] m_axis_tdata,
    output logic [CH_W-1:0]          m_axis_tuser
);

    localparam int ACC_W  = DATA_W + clog2(DEPTH);
    localparam int PROD_W = ACC_W + SCALE_W + 1;
    localparam logic signed [PROD_W-1:0] ROUND_C = PROD_W'(1) <<< (SHIFT - 1);

    logic                     w_en;
    logic                     w_accept;
    logic                     w_last;
    logic signed [DATA_W-1:0] w_old;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [PROD_W-1:0] w_acc_ext;
    logic signed [PROD_W-1:0] w_scale_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_sum;
    logic signed [PROD_W-1:0] w_round;

    logic [CH_W-1:0]          r_ch;
    logic signed [ACC_W-1:0]  r_acc [NUM_CH];

    logic                     r_s0_valid;
    logic [CH_W-1:0]          r_s0_ch;
    logic signed [ACC_W-1:0]  r_s0_acc;
    logic                     r_s1_valid;
    logic [CH_W-1:0]          r_s1_ch;
    logic signed [PROD_W-1:0] r_s1_prod;
    logic                     r_s2_valid;
    logic [CH_W-1:0]          r_s2_ch;
    logic signed [DATA_W-1:0] r_s2_data;

    assign w_en          = !r_s2_valid || m_axis_tready;
    assign w_accept      = s_axis_tvalid && w_en;
    assign w_last        = (r_ch == CH_W'(NUM_CH - 1));
    assign s_axis_tready = w_en;
    assign m_axis_tvalid = r_s2_valid;
    assign m_axis_tdata  = r_s2_data;
    assign m_axis_tuser  = r_s2_ch;

    ma_delay_line #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_delay_line (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_accept),
        .i_last (w_last),
        .i_ch   (r_ch),
        .i_data (s_axis_tdata),
        .o_old  (w_old)
    );

    assign w_acc_next = r_acc[r_ch]
                      + {{(ACC_W - DATA_W){s_axis_tdata[DATA_W-1]}}, s_axis_tdata}
                      - {{(ACC_W - DATA_W){w_old[DATA_W-1]}}, w_old};

    assign w_acc_ext   = {{(PROD_W - ACC_W){r_s0_acc[ACC_W-1]}}, r_s0_acc};
    assign w_scale_ext = {{(PROD_W - SCALE_W){1'b0}}, SCALE_W'(SCALE)};
    assign w_prod      = w_acc_ext * w_scale_ext;
    assign w_sum       = r_s1_prod + ROUND_C;
    assign w_round     = w_sum >>> SHIFT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch <= '0;
            for (int i = 0; i < NUM_CH; i++)
                r_acc[i] <= '0;
        end else if (w_accept) begin
            r_ch <= w_last ? '0 : r_ch + 1'b1;
            for (int i = 0; i < NUM_CH; i++)
                if (r_ch == CH_W'(i))
                    r_acc[i] <= w_acc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_ch    <= '0;
            r_s0_acc   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_ch    <= '0;
            r_s1_prod  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_ch    <= '0;
            r_s2_data  <= '0;
        end else if (w_en) begin
            r_s0_valid <= s_axis_tvalid;
            if (s_axis_tvalid) begin
                r_s0_ch  <= r_ch;
                r_s0_acc <= w_acc_next;
            end
            r_s1_valid <= r_s0_valid;
            r_s1_ch    <= r_s0_ch;
            r_s1_prod  <= w_prod;
            r_s2_valid <= r_s1_valid;
            r_s2_ch    <= r_s1_ch;
            r_s2_data  <= DATA_W'(sat({{(SAT_W - PROD_W){w_round[PROD_W-1]}}, w_round}, DATA_W));
        end
    end

endmodule

// File: tb/tb_axis_moving_average_mc.sv
// Bench for axis_moving_average_mc: three parameterisations, vector tables with a
// windowed-sum reference, and a scoreboard queue popped on each output handshake.
`timescale 1ns/1ps
module tb_axis_moving_average_mc;

    typedef struct {
        int x;
        int exp;
        int user;
    } vec_t;

    typedef struct {
        int data;
        int user;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          sel = 0;
    logic        drv_valid = 1'b0;
    logic        drv_ready = 1'b1;
    logic signed [31:0] drv_data = '0;
    bit          bp_mode = 1'b0;

    int   tests = 0;
    int   fails = 0;
    vec_t tbl[$];
    exp_t q[$];

    logic               v_a, v_m, v_s, r_a, r_m, r_s;
    logic               sr_a, sr_m, sr_s, mv_a, mv_m, mv_s;
    logic signed [31:0] md_a, md_m;
    logic signed [15:0] md_s;
    logic [0:0]         mu_a, mu_s;
    logic [1:0]         mu_m;

    logic               cur_m_valid, cur_s_ready;
    int                 cur_m_data, cur_m_user;

    always #5 clk = ~clk;

    assign v_a = drv_valid && (sel == 0);
    assign v_m = drv_valid && (sel == 1);
    assign v_s = drv_valid && (sel == 2);
    assign r_a = (sel == 0) ? drv_ready : 1'b1;
    assign r_m = (sel == 1) ? drv_ready : 1'b1;
    assign r_s = (sel == 2) ? drv_ready : 1'b1;

    axis_moving_average_mc u_a (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(v_a), .s_axis_tready(sr_a), .s_axis_tdata(drv_data),
        .m_axis_tvalid(mv_a), .m_axis_tready(r_a), .m_axis_tdata(md_a), .m_axis_tuser(mu_a)
    );

    axis_moving_average_mc #(.NUM_CH(3)) u_m (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(v_m), .s_axis_tready(sr_m), .s_axis_tdata(drv_data),
        .m_axis_tvalid(mv_m), .m_axis_tready(r_m), .m_axis_tdata(md_m), .m_axis_tuser(mu_m)
    );

    axis_moving_average_mc #(.DATA_W(16), .DEPTH(4), .SCALE(16384), .SHIFT(16)) u_s (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(v_s), .s_axis_tready(sr_s), .s_axis_tdata(drv_data[15:0]),
        .m_axis_tvalid(mv_s), .m_axis_tready(r_s), .m_axis_tdata(md_s), .m_axis_tuser(mu_s)
    );

    always_comb begin
        cur_m_valid = mv_a;
        cur_s_ready = sr_a;
        cur_m_data  = int'(md_a);
        cur_m_user  = int'(mu_a);
        if (sel == 1) begin
            cur_m_valid = mv_m;
            cur_s_ready = sr_m;
            cur_m_data  = int'(md_m);
            cur_m_user  = int'(mu_m);
        end else if (sel == 2) begin
            cur_m_valid = mv_s;
            cur_s_ready = sr_s;
            cur_m_data  = int'(md_s);
            cur_m_user  = int'(mu_s);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_y(input longint sum, input int scale, input int shift, input int dw);
        longint p;
        longint hi;
        p  = (sum * longint'(scale) + (64'sd1 <<< (shift - 1))) >>> shift;
        hi = (64'sd1 <<< (dw - 1)) - 1;
        if (p > hi) p = hi;
        if (p < -hi - 1) p = -hi - 1;
        return int'(p);
    endfunction

    // Expected value = scaled sum of the last min(k, depth) samples of that channel.
    function automatic void fill_exp(input int depth, input int nch, input int scale, input int shift, input int dw);
        for (int i = 0; i < tbl.size(); i++) begin
            longint sum = 0;
            int     n   = 0;
            for (int j = i; j >= 0 && n < depth; j -= nch) begin
                sum += longint'(tbl[j].x);
                n++;
            end
            tbl[i].exp  = ref_y(sum, scale, shift, dw);
            tbl[i].user = i % nch;
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        drv_valid = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input int x, input int exp_d, input int exp_u);
        bit done = 1'b0;
        drv_valid = 1'b1;
        drv_data  = x;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            if (cur_s_ready) begin
                q.push_back('{exp_d, exp_u});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: s_axis_tready stuck at 0 for x=%0d", x);
        end
    endtask

    task automatic run_range(input int first, input int last);
        for (int i = first; i < last; i++)
            send(tbl[i].x, tbl[i].exp, tbl[i].user);
        drv_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 3000 && q.size() != 0; t++)
            @(negedge clk);
        chk("drain_left", q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    always begin
        int burst;
        int r;
        burst = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!bp_mode) begin
                drv_ready = 1'b1;
                burst = 0;
            end else if (burst > 0) begin
                drv_ready = 1'b0;
                burst--;
            end else begin
                r = $urandom_range(0, 19);
                if (r == 0) begin
                    burst = 9;
                    drv_ready = 1'b0;
                end else begin
                    drv_ready = (r % 3 != 0);
                end
            end
        end
    end

    bit prev_stall = 1'b0;
    int prev_data  = 0;
    int prev_user  = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_hold", cur_m_valid, 1);
                chk("stall_data_hold", cur_m_data, prev_data);
                chk("stall_user_hold", cur_m_user, prev_user);
            end
            if (cur_m_valid && !drv_ready)
                chk("stall_s_ready", cur_s_ready, 0);
            if (cur_m_valid && drv_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got data %0d user %0d with empty scoreboard", cur_m_data, cur_m_user);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    $display("[TB] sel=%0d out data=%0d user=%0d exp=%0d/%0d", sel, cur_m_data, cur_m_user, e.data, e.user);
                    chk("out_data", cur_m_data, e.data);
                    chk("out_user", cur_m_user, e.user);
                end
            end
            prev_stall <= cur_m_valid && !drv_ready;
            prev_data  <= cur_m_data;
            prev_user  <= cur_m_user;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // DC step with reset values and first-output latency
        sel = 0;
        do_reset();
        tbl.delete();
        for (int i = 0; i < 100; i++) tbl.push_back('{1000, 0, 0});
        fill_exp(74, 1, 113359, 23, 32);
        drv_valid = 1'b1;
        drv_data  = tbl[0].x;
        @(negedge clk);
        chk("reset_s_ready", cur_s_ready, 1);
        chk("reset_m_valid", cur_m_valid, 0);
        chk("reset_m_data", cur_m_data, 0);
        chk("reset_m_user", cur_m_user, 0);
        q.push_back('{tbl[0].exp, 0});
        @(posedge clk);
        #1 drv_valid = 1'b0;
        @(negedge clk);
        chk("latency_edge_k", cur_m_valid, 0);
        @(negedge clk);
        chk("latency_edge_k1", cur_m_valid, 0);
        @(negedge clk);
        chk("latency_edge_k2", cur_m_valid, 1);
        @(posedge clk);
        #1;
        run_range(1, tbl.size());
        drain();

        // Impulse
        do_reset();
        tbl.delete();
        tbl.push_back('{74000, 0, 0});
        for (int i = 1; i < 80; i++) tbl.push_back('{0, 0, 0});
        fill_exp(74, 1, 113359, 23, 32);
        run_range(0, tbl.size());
        drain();

        // DC step under random backpressure
        do_reset();
        tbl.delete();
        for (int i = 0; i < 100; i++) tbl.push_back('{1000, 0, 0});
        fill_exp(74, 1, 113359, 23, 32);
        bp_mode = 1'b1;
        run_range(0, tbl.size());
        drain();
        bp_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-stream, then warm-up restarts
        do_reset();
        run_range(0, 40);
        chk("pre_reset_m_valid", cur_m_valid, 1);
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_m_valid", cur_m_valid, 0);
        chk("post_reset_m_data", cur_m_data, 0);
        @(posedge clk);
        #1;
        run_range(0, 80);
        drain();

        // Three interleaved channels
        sel = 1;
        do_reset();
        tbl.delete();
        for (int i = 0; i < 240; i++) tbl.push_back('{(i % 3 == 0) ? 300 : ((i % 3 == 1) ? -600 : 0), 0, 0});
        fill_exp(74, 3, 113359, 23, 32);
        run_range(0, tbl.size());
        drain();

        // Full-scale extremes at 16 bits
        sel = 2;
        do_reset();
        tbl.delete();
        for (int i = 0; i < 8; i++) tbl.push_back('{-32768, 0, 0});
        for (int i = 0; i < 8; i++) tbl.push_back('{32767, 0, 0});
        fill_exp(4, 1, 16384, 16, 16);
        run_range(0, tbl.size());
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
